// File: rtl/mdclcg_adder_scheduler.sv
// Sequencer that time-shares one three-operand adder across the x/y/p/q LCGs and
// emits one random bit per valid iteration on a valid/ready output.
module mdclcg_adder_scheduler #(
  parameter int          R1 = 2,
  parameter int          R2 = 3,
  parameter int          R3 = 4,
  parameter int          R4 = 5,
  parameter logic [15:0] B1 = 16'd1,
  parameter logic [15:0] B2 = 16'd3,
  parameter logic [15:0] B3 = 16'd5,
  parameter logic [15:0] B4 = 16'd7,
  parameter logic [15:0] SX = 16'd1,
  parameter logic [15:0] SY = 16'd2,
  parameter logic [15:0] SP = 16'd3,
  parameter logic [15:0] SQ = 16'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_we,
  input  logic [1:0]  seed_sel,
  input  logic [15:0] seed_data,
  input  logic        run,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic [15:0] add_c,
  output logic        add_cin,
  input  logic [16:0] add_sum,
  output logic        rnd_valid,
  output logic        rnd_bit,
  input  logic        rnd_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_X   = 3'd1,
    S_Y   = 3'd2,
    S_P   = 3'd3,
    S_Q   = 3'd4,
    S_CMP = 3'd5,
    S_OUT = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] x, y, p, q;
  logic        b_flag, c_flag;
  logic [15:0] sum16;
  logic        unused_bits;

  // The carry out of the adder is dropped: all recurrences are mod 2^16.
  assign sum16       = add_sum[15:0];
  assign unused_bits = ^{add_sum[16], b_flag, c_flag};
  assign add_cin     = 1'b0;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    add_a     = 16'd0;
    add_b     = 16'd0;
    add_c     = 16'd0;
    case (state)
      IDLE: begin
        if (!seed_we && run) state_nxt = S_X;
      end
      S_X: begin
        add_a     = x;
        add_b     = x << R1;
        add_c     = B1;
        state_nxt = S_Y;
      end
      S_Y: begin
        add_a     = y;
        add_b     = y << R2;
        add_c     = B2;
        state_nxt = S_P;
      end
      S_P: begin
        add_a     = p;
        add_b     = p << R3;
        add_c     = B3;
        state_nxt = S_Q;
      end
      S_Q: begin
        add_a     = q;
        add_b     = q << R4;
        add_c     = B4;
        state_nxt = S_CMP;
      end
      S_CMP: begin
        if (p > q)    state_nxt = S_OUT;
        else if (run) state_nxt = S_X;
        else          state_nxt = IDLE;
      end
      S_OUT: begin
        if (rnd_ready) state_nxt = run ? S_X : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= SX;
      y         <= SY;
      p         <= SP;
      q         <= SQ;
      b_flag    <= 1'b0;
      c_flag    <= 1'b0;
      rnd_valid <= 1'b0;
      rnd_bit   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (seed_we) begin
            case (seed_sel)
              2'd0: x <= seed_data;
              2'd1: y <= seed_data;
              2'd2: p <= seed_data;
              2'd3: q <= seed_data;
              default: ;
            endcase
          end
        end
        S_X: x <= sum16;
        S_Y: y <= sum16;
        S_P: p <= sum16;
        S_Q: q <= sum16;
        S_CMP: begin
          b_flag <= (x > y);
          c_flag <= (p > q);
          if (p > q) begin
            rnd_valid <= 1'b1;
            rnd_bit   <= (x > y);
          end
        end
        S_OUT: begin
          if (rnd_ready) rnd_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdclcg_adder_scheduler.sv
// Directed bench for mdclcg_adder_scheduler: an iteration-level model checked every cycle,
// plus hand-computed literal expectations for the scenarios of interest.
module tb_mdclcg_adder_scheduler;

  logic        clk;
  logic        rst;
  logic        seed_we;
  logic [1:0]  seed_sel;
  logic [15:0] seed_data;
  logic        run;
  logic [15:0] add_a, add_b, add_c;
  logic        add_cin;
  logic [16:0] add_sum;
  logic        rnd_valid, rnd_bit, rnd_ready, busy;

  int tests = 0;
  int fails = 0;

  mdclcg_adder_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .seed_we   (seed_we),
    .seed_sel  (seed_sel),
    .seed_data (seed_data),
    .run       (run),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .rnd_valid (rnd_valid),
    .rnd_bit   (rnd_bit),
    .rnd_ready (rnd_ready),
    .busy      (busy)
  );

  // Combinational three-operand adder the scheduler drives.
  assign add_sum = 17'(add_a) + 17'(add_b) + 17'(add_c) + 17'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1..4 updating recurrence phase-1, 5 compare, 6 bit offered
  int          rr[4] = '{2, 3, 4, 5};
  logic [15:0] bb[4] = '{16'd1, 16'd3, 16'd5, 16'd7};
  logic [15:0] ms[4];
  int          mph  = 0;
  logic        mvld = 1'b0;
  logic        mbit = 1'b0;
  logic        chk_en = 1'b0;

  function automatic logic [15:0] lcg(input logic [15:0] s, input int r, input logic [15:0] b);
    logic [31:0] t;
    t = {16'd0, s} + ({16'd0, s} << r) + {16'd0, b};
    return t[15:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ms[0] <= 16'd1;
      ms[1] <= 16'd2;
      ms[2] <= 16'd3;
      ms[3] <= 16'd4;
      mph   <= 0;
      mvld  <= 1'b0;
      mbit  <= 1'b0;
    end else begin
      case (mph)
        0: begin
          if (seed_we)  ms[seed_sel] <= seed_data;
          else if (run) mph <= 1;
        end
        1, 2, 3, 4: begin
          ms[mph-1] <= lcg(ms[mph-1], rr[mph-1], bb[mph-1]);
          mph       <= mph + 1;
        end
        5: begin
          if (ms[2] > ms[3]) begin
            mvld <= 1'b1;
            mbit <= (ms[0] > ms[1]);
            mph  <= 6;
          end else begin
            mph <= run ? 1 : 0;
          end
        end
        6: begin
          if (rnd_ready) begin
            mvld <= 1'b0;
            mph  <= run ? 1 : 0;
          end
        end
        default: mph <= 0;
      endcase
    end
  end

  logic [15:0] ea, eb, ec;
  always @(negedge clk) begin
    if (chk_en) begin
      if (mph >= 1 && mph <= 4) begin
        ea = ms[mph-1];
        eb = 16'(ms[mph-1] << rr[mph-1]);
        ec = bb[mph-1];
      end else begin
        ea = 16'd0;
        eb = 16'd0;
        ec = 16'd0;
      end
      check("cycle_operands", 64'({add_a, add_b, add_c, add_cin}), 64'({ea, eb, ec, 1'b0}));
      check("cycle_handshake", 64'({busy, rnd_valid, rnd_bit}), 64'({(mph != 0), mvld, mbit}));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_seed(input logic [1:0] sel, input logic [15:0] data);
    seed_we   = 1'b1;
    seed_sel  = sel;
    seed_data = data;
    tick();
    seed_we   = 1'b0;
  endtask

  task automatic run_pulse();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && busy; i++) tick();
    check(name, 64'(busy), 64'(0));
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && !rnd_valid; i++) tick();
    check(name, 64'(rnd_valid), 64'(1));
  endtask

  task automatic load_valid_seeds();
    write_seed(2'd0, 16'd10);
    write_seed(2'd1, 16'd0);
    write_seed(2'd2, 16'd100);
    write_seed(2'd3, 16'd0);
  endtask

  initial begin
    rst = 1'b1; seed_we = 1'b0; seed_sel = 2'd0; seed_data = 16'd0;
    run = 1'b0; rnd_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_valid", 64'(rnd_valid), 64'(0));
    check("reset_bit", 64'(rnd_bit), 64'(0));
    check("reset_add_a", 64'(add_a), 64'(0));

    // Default seeds: x=6 y=21 p=56 q=139, p<q so discarded and the loop restarts.
    run = 1'b1;
    tick(); check("t1_sx_a", 64'(add_a), 64'(1)); check("t1_sx_b", 64'(add_b), 64'(4));
    tick(); check("t1_sy_a", 64'(add_a), 64'(2));
    tick(); check("t1_sp_a", 64'(add_a), 64'(3));
    tick(); check("t1_sq_a", 64'(add_a), 64'(4)); check("t1_sq_c", 64'(add_c), 64'(7));
    tick(); // compare
    tick(); check("t1_x6", 64'(add_a), 64'(6)); check("t1_discard", 64'(rnd_valid), 64'(0));
    tick(); check("t1_y21", 64'(add_a), 64'(21));
    tick(); check("t1_p56", 64'(add_a), 64'(56));
    tick(); check("t1_q139", 64'(add_a), 64'(139));
    run = 1'b0;
    tick();
    tick(); check("t1_idle", 64'(busy), 64'(0));

    // x=10 y=0 p=100 q=0 -> 51,3,1705,7: bit 1, then held under backpressure.
    load_valid_seeds();
    run_pulse();
    check("t2_sx_a", 64'(add_a), 64'(10)); check("t2_sx_b", 64'(add_b), 64'(40));
    tick(); check("t2_sy_a", 64'(add_a), 64'(0));
    tick(); check("t2_sp_a", 64'(add_a), 64'(100));
    tick(); check("t2_sq_a", 64'(add_a), 64'(0));
    tick(); check("t2_cmp_valid", 64'(rnd_valid), 64'(0));
    tick(); check("t2_out_valid", 64'(rnd_valid), 64'(1)); check("t2_out_bit", 64'(rnd_bit), 64'(1));
    seed_we = 1'b1; seed_sel = 2'd0; seed_data = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      check("t2_hold", 64'({rnd_valid, rnd_bit, busy}), 64'(3'b111));
      tick();
    end
    seed_we = 1'b0;
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
    check("t2_accept_valid", 64'(rnd_valid), 64'(0));
    check("t2_accept_idle", 64'(busy), 64'(0));
    run_pulse();
    check("t2_seed_ignored_x51", 64'(add_a), 64'(51));
    tick(); check("t2_y3", 64'(add_a), 64'(3));
    tick(); check("t2_p1705", 64'(add_a), 64'(1705));
    tick(); check("t2_q7", 64'(add_a), 64'(7));
    rnd_ready = 1'b1;
    wait_idle("t2_done", 20);
    rnd_ready = 1'b0;

    // Wrap-around on x.
    write_seed(2'd0, 16'hFFFF);
    run_pulse();
    check("t3_a", 64'(add_a), 64'h0FFFF);
    check("t3_b", 64'(add_b), 64'h0FFFC);
    check("t3_c", 64'(add_c), 64'h1);
    check("t3_sum", 64'(add_sum), 64'h1FFFC);
    rnd_ready = 1'b1;
    wait_idle("t3_done", 20);
    rnd_ready = 1'b0;

    // Reset during S_P.
    run_pulse();
    check("t4_x_wrapped", 64'(add_a), 64'h0FFFC);
    tick();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t4_rst_idle", 64'(busy), 64'(0));
    check("t4_rst_valid", 64'(rnd_valid), 64'(0));
    run_pulse();
    check("t4_x1", 64'(add_a), 64'(1));
    tick(); check("t4_y2", 64'(add_a), 64'(2));
    tick(); check("t4_p3", 64'(add_a), 64'(3));
    tick(); check("t4_q4", 64'(add_a), 64'(4));
    wait_idle("t4_done", 20);

    // Reset while a bit is being offered.
    load_valid_seeds();
    run_pulse();
    wait_valid("t5_valid", 20);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_rst_valid", 64'(rnd_valid), 64'(0));
    check("t5_rst_bit", 64'(rnd_bit), 64'(0));
    check("t5_rst_idle", 64'(busy), 64'(0));
    run_pulse();
    check("t5_x1", 64'(add_a), 64'(1));
    tick(); check("t5_y2", 64'(add_a), 64'(2));
    tick(); check("t5_p3", 64'(add_a), 64'(3));
    tick(); check("t5_q4", 64'(add_a), 64'(4));
    wait_idle("t5_done", 20);

    // Seed write and run together: write wins, start one cycle later.
    seed_we = 1'b1; seed_sel = 2'd0; seed_data = 16'd7; run = 1'b1;
    tick();
    seed_we = 1'b0;
    check("t6_stay_idle", 64'(busy), 64'(0));
    tick();
    run = 1'b0;
    check("t6_started", 64'(busy), 64'(1));
    check("t6_x7", 64'(add_a), 64'(7));
    rnd_ready = 1'b1;
    wait_idle("t6_done", 20);
    rnd_ready = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
